// File: rtl/instruction_memory_sync.sv
// instruction_memory_sync: byte-addressed, little-endian instruction memory
// with a registered valid/ready fetch port, optional wait states, fault
// reporting (misaligned / out of range) and a byte-wide program load port.
// Optional feature macro: IMEM_PRELOAD_EN gives the array defined contents
// from time 0.
module instruction_memory_sync #(
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DEPTH_BYTES = 65536,
  parameter int    INSTR_WIDTH = 32,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "imem.hex"
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [INSTR_WIDTH-1:0] rsp_instr,
  output logic [1:0]             rsp_fault,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [7:0]             load_data
);

  localparam int NB    = INSTR_WIDTH / 8;
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  // Range arithmetic is done one bit wider than the address so that
  // addresses near the top of the address space cannot wrap into range.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH:0]   SPAN_EXT  = (ADDR_WIDTH+1)'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] NB_A      = ADDR_WIDTH'(NB);
  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;

  logic [7:0] mem [0:DEPTH_BYTES-1];

  logic                   accept;
  logic                   load_hit;
  logic [1:0]             fetch_fault;
  logic [INSTR_WIDTH-1:0] fetch_word;

  assign accept   = req_valid && req_ready;
  assign load_hit = load_en && ({1'b0, load_addr} < DEPTH_EXT);

`ifdef IMEM_PRELOAD_EN
  // Start from a zeroed array so contents are defined from time 0.
  initial begin
    for (int i = 0; i < DEPTH_BYTES; i++) mem[i] = 8'h00;
  end
`endif

  // Byte load port; out-of-range loads are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (load_hit) mem[load_addr[IDX_W-1:0]] <= load_data;
  end

  // Fault classification of the presented fetch address; misaligned wins.
  always_comb begin
    fetch_fault = 2'b00;
    if ((req_addr % NB_A) != '0)
      fetch_fault = 2'b01;
    else if (({1'b0, req_addr} + SPAN_EXT) >= DEPTH_EXT)
      fetch_fault = 2'b10;
  end

  // Little-endian word assembly; the array is only indexed for legal fetches.
  always_comb begin
    fetch_word = '0;
    if (fetch_fault == 2'b00) begin
      for (int i = 0; i < NB; i++)
        fetch_word[8*i +: 8] = mem[req_addr[IDX_W-1:0] + IDX_W'(i)];
    end
  end

  // Next-state logic for the fetch handshake and wait-state counter.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_next = RESP;
        else                  wait_cnt_next = wait_cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; handshake outputs are registered from the next state so
  // that req_ready stays low during reset and rises on the first clock after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
    end
  end

  // Response register captured at acceptance and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_instr <= '0;
      rsp_fault <= 2'b00;
    end else if (accept) begin
      rsp_instr <= fetch_word;
      rsp_fault <= fetch_fault;
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// tb_instruction_memory_sync: two instances (0 and 3 wait states) sharing the
// load port, checked against a byte-array model of the memory.
module tb_instruction_memory_sync;

  localparam int DEPTH = 65536;
  localparam int WS0   = 0;
  localparam int WS1   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_addr = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [1:0][31:0] rsp_instr;
  logic [1:0][1:0]  rsp_fault;
  logic             load_en = 1'b0;
  logic [31:0]      load_addr = '0;
  logic [7:0]       load_data = '0;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [7:0] model_mem [int];

  always #5 clk = ~clk;

  instruction_memory_sync #(.WAIT_STATES(WS0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_instr(rsp_instr[0]), .rsp_fault(rsp_fault[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instruction_memory_sync #(.WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_instr(rsp_instr[1]), .rsp_fault(rsp_fault[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_cnt++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    else
      pass_cnt++;
  endtask

  // Reference fetch: {fault, instr} derived from address arithmetic on the model.
  function automatic logic [33:0] modelFetch(input logic [31:0] addr);
    longint unsigned a;
    a = addr;
    if (a % 4 != 0) return {2'b01, 32'h0};
    if (a + 3 >= DEPTH) return {2'b10, 32'h0};
    return {2'b00, model_mem[int'(a+3)], model_mem[int'(a+2)],
            model_mem[int'(a+1)], model_mem[int'(a)]};
  endfunction

  // Entered and left on a falling edge.
  task automatic loadByte(input logic [31:0] addr, input logic [7:0] data);
    load_en = 1'b1;
    load_addr = addr;
    load_data = data;
    if (addr < DEPTH) model_mem[int'(addr)] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic loadWord(input logic [31:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) loadByte(addr + i, w[8*i +: 8]);
  endtask

  // One complete fetch on instance d with optional same-edge collision load,
  // optional load to the fetched byte after acceptance, and rsp_ready stall.
  task automatic applyStimulus(input int d, input logic [31:0] addr, input int stall,
                               input bit coll_en, input logic [31:0] coll_addr,
                               input logic [7:0] coll_data, input bit scribble);
    logic [33:0] exp;
    logic [31:0] held_i;
    logic [1:0]  held_f;
    int lat;
    int ws;
    bit ready_seen;
    bit stable;
    exp = modelFetch(addr);
    ws = (d == 0) ? WS0 : WS1;
    lat = 0;
    while (req_ready[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("ready_before", req_ready[d], 1);
    req_valid[d] = 1'b1;
    req_addr[d] = addr;
    if (coll_en) begin
      load_en = 1'b1;
      load_addr = coll_addr;
      load_data = coll_data;
      if (coll_addr < DEPTH) model_mem[int'(coll_addr)] = coll_data;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d] = $urandom();
    load_en = 1'b0;
    if (scribble && exp[33:32] == 2'b00) begin
      load_en = 1'b1;
      load_addr = addr;
      load_data = ~model_mem[int'(addr)];
      model_mem[int'(addr)] = load_data;
    end
    lat = 1;
    ready_seen = 1'b0;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      ready_seen |= req_ready[d];
      @(negedge clk);
      load_en = 1'b0;
      lat++;
    end
    ready_seen |= req_ready[d];
    checkOutput("latency", lat, 1 + ws);
    checkOutput("ready_busy", ready_seen, 0);
    checkOutput("instr", rsp_instr[d], exp[31:0]);
    checkOutput("fault", rsp_fault[d], exp[33:32]);
    held_i = rsp_instr[d];
    held_f = rsp_fault[d];
    stable = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      load_en = 1'b0;
      if (rsp_valid[d] !== 1'b1 || rsp_instr[d] !== held_i ||
          rsp_fault[d] !== held_f || req_ready[d] !== 1'b0) stable = 1'b0;
    end
    if (stall > 0) checkOutput("hold", stable, 1);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    rsp_ready[d] = 1'b0;
    checkOutput("rsp_done", rsp_valid[d], 0);
    checkOutput("ready_after", req_ready[d], 1);
    checkOutput("instr_held", rsp_instr[d], held_i);
  endtask

  // Hard time bound so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    bit flag;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", rsp_valid, 2'b00);
    checkOutput("rst_ready", req_ready, 2'b00);
    checkOutput("rst_instr", {rsp_instr[1], rsp_instr[0]}, 64'h0);
    checkOutput("rst_fault", {rsp_fault[1], rsp_fault[0]}, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_first", req_ready, 2'b11);

    // Program load, then an out-of-range load that must not alias byte 0.
    loadWord(32'h0, 32'h00100093);
    loadByte(DEPTH, 8'h55);
    applyStimulus(0, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("spec_w0", rsp_instr[0], 32'h00100093);

    // Wait states with backpressure.
    loadWord(32'h4, 32'h00200113);
    applyStimulus(1, 32'h4, 5, 0, 0, 0, 0);
    checkOutput("spec_w4", rsp_instr[1], 32'h00200113);

    // Faults and the last legal word.
    loadWord(DEPTH - 4, 32'hFF0032B8);
    applyStimulus(0, 32'h2, 0, 0, 0, 0, 0);
    checkOutput("spec_mis", rsp_fault[0], 2'b01);
    applyStimulus(0, DEPTH - 2, 1, 0, 0, 0, 0);
    checkOutput("spec_mis_top", rsp_fault[0], 2'b01);
    applyStimulus(0, DEPTH - 4, 0, 0, 0, 0, 0);
    checkOutput("spec_last", rsp_instr[0], 32'hFF0032B8);
    applyStimulus(0, DEPTH, 0, 0, 0, 0, 0);
    checkOutput("spec_oor", rsp_fault[0], 2'b10);
    applyStimulus(1, 32'hFFFFFFFC, 2, 0, 0, 0, 0);
    checkOutput("spec_nowrap", rsp_fault[1], 2'b10);

    // Load and fetch acceptance on the same edge to the same byte.
    loadWord(32'h8, 32'h401111B3);
    applyStimulus(0, 32'h8, 0, 1, 32'h8, 8'hEE, 0);
    checkOutput("spec_coll_old", rsp_instr[0], 32'h401111B3);
    applyStimulus(0, 32'h8, 0, 0, 0, 0, 0);
    checkOutput("spec_coll_new", rsp_instr[0], 32'h401111EE);

    // Randomized fetches over a loaded region, faults and late loads.
    for (int i = 0; i < 16; i++) loadWord(32'h100 + 4*i, $urandom());
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3, 0))
        0: a = 32'h100 + 4*$urandom_range(15, 0);
        1: a = 32'h100 + 4*$urandom_range(15, 0) + $urandom_range(3, 1);
        2: a = $urandom_range(32'hFFFFFFFF, DEPTH);
        default: a = DEPTH - 4 + $urandom_range(7, 0);
      endcase
      if ($urandom_range(3, 0) == 0) loadByte(32'h100 + $urandom_range(63, 0), $urandom());
      applyStimulus($urandom_range(1, 0), a, $urandom_range(3, 0), 0, 0, 0,
                    $urandom_range(1, 0));
    end

    // Reset while a fetch is in its wait states.
    applyStimulus(1, 32'h4, 0, 0, 0, 0, 0);
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h4;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", rsp_valid[1], 0);
    checkOutput("midrst_ready", req_ready[1], 0);
    checkOutput("midrst_instr", rsp_instr[1], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      flag |= rsp_valid[1];
    end
    checkOutput("midrst_no_rsp", flag, 0);
    checkOutput("midrst_idle", req_ready[1], 1);
    applyStimulus(1, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("midrst_retain", rsp_instr[1], 32'h00100093);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
